// File: rtl/ren_free_list.sv
// Rename-stage physical register free list: circular FIFO of free PRF codes with
// speculative/committed allocation pointers, 4-wide allocate and 4-wide release.
module ren_free_list #(
  parameter int unsigned PRF_NUMS       = 128,
  parameter int unsigned PRF_CODE_WIDTH = 7,
  parameter int unsigned ARF_NUMS       = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_ren_alloc_req_0,
  input  logic                      i_ren_alloc_req_1,
  input  logic                      i_ren_alloc_req_2,
  input  logic                      i_ren_alloc_req_3,
  output logic                      o_ren_alloc_ready,
  output logic [PRF_CODE_WIDTH-1:0] o_ren_alloc_code_0,
  output logic [PRF_CODE_WIDTH-1:0] o_ren_alloc_code_1,
  output logic [PRF_CODE_WIDTH-1:0] o_ren_alloc_code_2,
  output logic [PRF_CODE_WIDTH-1:0] o_ren_alloc_code_3,
  output logic                      o_ren_prf_free_req_0,
  output logic                      o_ren_prf_free_req_1,
  output logic                      o_ren_prf_free_req_2,
  output logic                      o_ren_prf_free_req_3,
  output logic [PRF_CODE_WIDTH-1:0] o_ren_prf_free_prf_code_0,
  output logic [PRF_CODE_WIDTH-1:0] o_ren_prf_free_prf_code_1,
  output logic [PRF_CODE_WIDTH-1:0] o_ren_prf_free_prf_code_2,
  output logic [PRF_CODE_WIDTH-1:0] o_ren_prf_free_prf_code_3,
  input  logic [2:0]                i_rob_commit_cnt,
  input  logic                      i_rob_release_req_0,
  input  logic                      i_rob_release_req_1,
  input  logic                      i_rob_release_req_2,
  input  logic                      i_rob_release_req_3,
  input  logic [PRF_CODE_WIDTH-1:0] i_rob_release_code_0,
  input  logic [PRF_CODE_WIDTH-1:0] i_rob_release_code_1,
  input  logic [PRF_CODE_WIDTH-1:0] i_rob_release_code_2,
  input  logic [PRF_CODE_WIDTH-1:0] i_rob_release_code_3,
  input  logic                      i_flush,
  output logic [PRF_CODE_WIDTH:0]   o_free_cnt
);

  localparam int unsigned CW    = PRF_CODE_WIDTH;
  localparam int unsigned PW    = PRF_CODE_WIDTH + 1;
  localparam int unsigned LANES = 4;
  localparam int unsigned INIT_FREE = PRF_NUMS - ARF_NUMS;

  logic [CW-1:0] fifo [PRF_NUMS];
  logic [PW-1:0] spec_head, arch_head, tail;
  logic [PW-1:0] spec_head_nxt, arch_head_nxt, tail_nxt;
  logic [PW-1:0] free_cnt;

  logic [LANES-1:0] alloc_req;
  logic [LANES-1:0] alloc_grant;
  logic [2:0]       alloc_off [LANES];
  logic [CW-1:0]    alloc_idx [LANES];
  logic [CW-1:0]    alloc_code [LANES];
  logic [2:0]       nreq;
  logic             alloc_ready;

  logic [LANES-1:0] rel_req;
  logic [LANES-1:0] rel_valid;
  logic [CW-1:0]    rel_code [LANES];
  logic [2:0]       rel_off [LANES];
  logic [CW-1:0]    rel_idx [LANES];
  logic [2:0]       nrel;

  assign alloc_req   = {i_ren_alloc_req_3, i_ren_alloc_req_2, i_ren_alloc_req_1, i_ren_alloc_req_0};
  assign rel_req     = {i_rob_release_req_3, i_rob_release_req_2, i_rob_release_req_1, i_rob_release_req_0};
  assign rel_code[0] = i_rob_release_code_0;
  assign rel_code[1] = i_rob_release_code_1;
  assign rel_code[2] = i_rob_release_code_2;
  assign rel_code[3] = i_rob_release_code_3;

  assign free_cnt = tail - spec_head;

  // Allocation: compact requesting lanes onto consecutive entries from spec_head, all-or-nothing.
  always_comb begin
    nreq = '0;
    for (int n = 0; n < LANES; n++) begin
      alloc_off[n] = nreq;
      nreq         = nreq + 3'(alloc_req[n]);
    end
    alloc_ready = !i_flush && (free_cnt >= PW'(nreq));
    for (int n = 0; n < LANES; n++) begin
      alloc_idx[n]   = spec_head[CW-1:0] + CW'(alloc_off[n]);
      alloc_grant[n] = alloc_ready && alloc_req[n];
      alloc_code[n]  = alloc_grant[n] ? fifo[alloc_idx[n]] : '0;
    end
  end

  // Release: code 0 is never a real stale mapping, so it is dropped rather than queued.
  always_comb begin
    nrel = '0;
    for (int n = 0; n < LANES; n++) begin
      rel_valid[n] = rel_req[n] && (rel_code[n] != '0);
      rel_off[n]   = nrel;
      rel_idx[n]   = tail[CW-1:0] + CW'(nrel);
      nrel         = nrel + 3'(rel_valid[n]);
    end
  end

  // Pointer next-state; a flush rewinds spec_head to the committed point including this cycle's commits.
  always_comb begin
    spec_head_nxt = spec_head;
    arch_head_nxt = arch_head + PW'(i_rob_commit_cnt);
    tail_nxt      = tail + PW'(nrel);
    if (i_flush) begin
      spec_head_nxt = arch_head + PW'(i_rob_commit_cnt);
    end else if (alloc_ready) begin
      spec_head_nxt = spec_head + PW'(nreq);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spec_head <= '0;
      arch_head <= '0;
      tail      <= PW'(INIT_FREE);
    end else begin
      spec_head <= spec_head_nxt;
      arch_head <= arch_head_nxt;
      tail      <= tail_nxt;
    end
  end

  // Entry storage; reset preloads every non-architectural code in ascending order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PRF_NUMS; k++) begin
        fifo[k] <= (k < INIT_FREE) ? CW'(ARF_NUMS + k) : '0;
      end
    end else begin
      for (int n = 0; n < LANES; n++) begin
        if (rel_valid[n]) fifo[rel_idx[n]] <= rel_code[n];
      end
    end
  end

  assign o_ren_alloc_ready         = alloc_ready;
  assign o_ren_alloc_code_0        = alloc_code[0];
  assign o_ren_alloc_code_1        = alloc_code[1];
  assign o_ren_alloc_code_2        = alloc_code[2];
  assign o_ren_alloc_code_3        = alloc_code[3];
  assign o_ren_prf_free_req_0      = alloc_grant[0];
  assign o_ren_prf_free_req_1      = alloc_grant[1];
  assign o_ren_prf_free_req_2      = alloc_grant[2];
  assign o_ren_prf_free_req_3      = alloc_grant[3];
  assign o_ren_prf_free_prf_code_0 = alloc_code[0];
  assign o_ren_prf_free_prf_code_1 = alloc_code[1];
  assign o_ren_prf_free_prf_code_2 = alloc_code[2];
  assign o_ren_prf_free_prf_code_3 = alloc_code[3];
  assign o_free_cnt                = free_cnt;

endmodule

// File: tb/tb_ren_free_list.sv
// Directed bench for ren_free_list: vector table plus hand sequences for exhaustion, wrap and reset.
module tb_ren_free_list;

  typedef struct {
    logic [3:0]      req;
    logic [2:0]      commit;
    logic            flush;
    logic [3:0]      rel_req;
    logic [3:0][6:0] rel_code;
    logic            ready;
    logic [3:0][6:0] code;
    logic [7:0]      cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] req;
  logic ready;
  logic [6:0] code0, code1, code2, code3;
  logic fr0, fr1, fr2, fr3;
  logic [6:0] fc0, fc1, fc2, fc3;
  logic [2:0] commit;
  logic [3:0] rel_req;
  logic [3:0][6:0] rel_code;
  logic flush;
  logic [7:0] free_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ren_free_list dut (
    .clk(clk), .rst(rst),
    .i_ren_alloc_req_0(req[0]), .i_ren_alloc_req_1(req[1]),
    .i_ren_alloc_req_2(req[2]), .i_ren_alloc_req_3(req[3]),
    .o_ren_alloc_ready(ready),
    .o_ren_alloc_code_0(code0), .o_ren_alloc_code_1(code1),
    .o_ren_alloc_code_2(code2), .o_ren_alloc_code_3(code3),
    .o_ren_prf_free_req_0(fr0), .o_ren_prf_free_req_1(fr1),
    .o_ren_prf_free_req_2(fr2), .o_ren_prf_free_req_3(fr3),
    .o_ren_prf_free_prf_code_0(fc0), .o_ren_prf_free_prf_code_1(fc1),
    .o_ren_prf_free_prf_code_2(fc2), .o_ren_prf_free_prf_code_3(fc3),
    .i_rob_commit_cnt(commit),
    .i_rob_release_req_0(rel_req[0]), .i_rob_release_req_1(rel_req[1]),
    .i_rob_release_req_2(rel_req[2]), .i_rob_release_req_3(rel_req[3]),
    .i_rob_release_code_0(rel_code[0]), .i_rob_release_code_1(rel_code[1]),
    .i_rob_release_code_2(rel_code[2]), .i_rob_release_code_3(rel_code[3]),
    .i_flush(flush),
    .o_free_cnt(free_cnt)
  );

  function automatic vec_t mkv(logic [3:0] r, logic [2:0] cm, logic fl, logic [3:0] rr,
                               logic [3:0][6:0] rc, logic rdy, logic [3:0][6:0] c, int cnt);
    vec_t v;
    v.req = r; v.commit = cm; v.flush = fl; v.rel_req = rr; v.rel_code = rc;
    v.ready = rdy; v.code = c; v.cnt = 8'(cnt);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    req = '0; commit = '0; flush = 1'b0; rel_req = '0; rel_code = '0;
  endtask

  // Apply one vector after a rising edge, check combinational outputs at the falling edge.
  task automatic cyc(input vec_t v, input string tag);
    logic [3:0] exp_fr;
    logic [3:0][6:0] act_c;
    logic [3:0] act_fr;
    logic [3:0][6:0] act_fc;
    req = v.req; commit = v.commit; flush = v.flush; rel_req = v.rel_req; rel_code = v.rel_code;
    @(negedge clk);
    exp_fr = v.ready ? v.req : 4'b0000;
    act_c  = {code3, code2, code1, code0};
    act_fr = {fr3, fr2, fr1, fr0};
    act_fc = {fc3, fc2, fc1, fc0};
    chk({tag, " ready"}, int'(ready), int'(v.ready));
    chk({tag, " free_cnt"}, int'(free_cnt), int'(v.cnt));
    chk({tag, " free_req"}, int'(act_fr), int'(exp_fr));
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("%s code%0d", tag, n), int'(act_c[n]), int'(v.code[n]));
      chk($sformatf("%s prf_code%0d", tag, n), int'(act_fc[n]), int'(v.code[n]));
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  vec_t tbl [10];
  logic [3:0][6:0] z;
  logic [3:0][6:0] c;

  initial begin
    z = '0;
    // Directed vectors from reset: compaction, commit, flush rewind, release of code 0.
    tbl[0] = mkv(4'b0000, 3'd0, 1'b0, 4'b0000, z, 1'b1, z, 96);
    tbl[1] = mkv(4'b1010, 3'd0, 1'b0, 4'b0000, z, 1'b1, {7'd33, 7'd0, 7'd32, 7'd0}, 96);
    tbl[2] = mkv(4'b1111, 3'd0, 1'b0, 4'b0000, z, 1'b1, {7'd37, 7'd36, 7'd35, 7'd34}, 94);
    tbl[3] = mkv(4'b0001, 3'd4, 1'b0, 4'b0000, z, 1'b1, {7'd0, 7'd0, 7'd0, 7'd38}, 90);
    tbl[4] = mkv(4'b1111, 3'd0, 1'b1, 4'b0000, z, 1'b0, z, 89);
    tbl[5] = mkv(4'b0001, 3'd0, 1'b0, 4'b0000, z, 1'b1, {7'd0, 7'd0, 7'd0, 7'd36}, 92);
    tbl[6] = mkv(4'b0000, 3'd0, 1'b0, 4'b0011, {7'd0, 7'd0, 7'd0, 7'd5}, 1'b1, z, 91);
    tbl[7] = mkv(4'b0000, 3'd0, 1'b0, 4'b0000, z, 1'b1, z, 92);
    tbl[8] = mkv(4'b0001, 3'd1, 1'b1, 4'b0000, z, 1'b0, z, 92);
    tbl[9] = mkv(4'b0000, 3'd0, 1'b0, 4'b0000, z, 1'b1, z, 92);

    rst = 1'b1;
    drive_idle();
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 10; i++) cyc(tbl[i], $sformatf("tbl%0d", i));

    // Exhaustion: take 94 codes, a 4-wide request is refused, then 2 lanes get 126,127.
    do_reset();
    for (int i = 0; i < 23; i++) begin
      c = {7'(35 + 4 * i), 7'(34 + 4 * i), 7'(33 + 4 * i), 7'(32 + 4 * i)};
      cyc(mkv(4'b1111, 3'd0, 1'b0, 4'b0000, z, 1'b1, c, 96 - 4 * i), $sformatf("exh%0d", i));
    end
    cyc(mkv(4'b0011, 3'd0, 1'b0, 4'b0000, z, 1'b1, {7'd0, 7'd0, 7'd125, 7'd124}, 4), "exh_two");
    cyc(mkv(4'b1111, 3'd0, 1'b0, 4'b0000, z, 1'b0, z, 2), "exh_refuse");
    cyc(mkv(4'b0000, 3'd0, 1'b0, 4'b0000, z, 1'b1, z, 2), "exh_hold");
    cyc(mkv(4'b0101, 3'd0, 1'b0, 4'b0000, z, 1'b1, {7'd0, 7'd127, 7'd0, 7'd126}, 2), "exh_last");
    cyc(mkv(4'b0000, 3'd0, 1'b0, 4'b0000, z, 1'b1, z, 0), "exh_empty");
    cyc(mkv(4'b0010, 3'd0, 1'b0, 4'b0000, z, 1'b0, z, 0), "exh_one_refused");

    // Wrap: commit everything, refill entries 96..127, then code 5 lands at index 0.
    for (int i = 0; i < 24; i++)
      cyc(mkv(4'b0000, 3'd4, 1'b0, 4'b0000, z, 1'b1, z, 0), $sformatf("cmt%0d", i));
    for (int i = 0; i < 8; i++) begin
      c = {7'(13 + 4 * i), 7'(12 + 4 * i), 7'(11 + 4 * i), 7'(10 + 4 * i)};
      cyc(mkv(4'b0000, 3'd0, 1'b0, 4'b1111, c, 1'b1, z, 4 * i), $sformatf("rel%0d", i));
    end
    cyc(mkv(4'b0000, 3'd0, 1'b0, 4'b0011, {7'd0, 7'd0, 7'd0, 7'd5}, 1'b1, z, 32), "rel_5_0");
    cyc(mkv(4'b0000, 3'd0, 1'b0, 4'b0000, z, 1'b1, z, 33), "rel_only_one");
    for (int i = 0; i < 8; i++) begin
      c = {7'(13 + 4 * i), 7'(12 + 4 * i), 7'(11 + 4 * i), 7'(10 + 4 * i)};
      cyc(mkv(4'b1111, 3'd0, 1'b0, 4'b0000, z, 1'b1, c, 33 - 4 * i), $sformatf("wrap%0d", i));
    end
    cyc(mkv(4'b1000, 3'd0, 1'b0, 4'b0000, z, 1'b1, {7'd5, 7'd0, 7'd0, 7'd0}, 1), "wrap_code5");
    cyc(mkv(4'b0000, 3'd0, 1'b0, 4'b0000, z, 1'b1, z, 0), "wrap_empty");

    // Reset overriding simultaneous alloc, release, commit and flush.
    req = 4'b1111; commit = 3'd2; flush = 1'b1; rel_req = 4'b0001; rel_code = {7'd0, 7'd0, 7'd0, 7'd9};
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();
    cyc(mkv(4'b0000, 3'd0, 1'b0, 4'b0000, z, 1'b1, z, 96), "rst_idle");
    cyc(mkv(4'b1111, 3'd0, 1'b0, 4'b0000, z, 1'b1, {7'd35, 7'd34, 7'd33, 7'd32}, 96), "rst_alloc");
    cyc(mkv(4'b0000, 3'd0, 1'b0, 4'b0000, z, 1'b1, z, 92), "rst_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
